// File: rtl/reg_scoreboard.sv
// Register-busy scoreboard: one busy bit per architectural register, set on issue,
// cleared on writeback. Optional macro SCOREBOARD_CLR_BYPASS_EN lets source queries see same-cycle clears.
module reg_scoreboard #(
  parameter int N             = 5,
  parameter bit HARDWIRE_ZERO = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            set_valid,
  input  logic [N-1:0]    set_idx,
  output logic            set_ready,
  input  logic            clr_valid,
  input  logic [N-1:0]    clr_idx,
  input  logic [N-1:0]    rs1_idx,
  input  logic [N-1:0]    rs2_idx,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic [2**N-1:0] busy_vec,
  output logic [N:0]      busy_count,
  output logic            any_busy,
  output logic            clr_err
);

  localparam int R = 2**N;

  logic [R-1:0] busy_q, busy_d, set_oh, clr_oh;
  logic [N:0]   count_q, count_d;
  logic         clr_err_q, clr_err_d;
  logic         set_acc, set_new, clr_hit, set_zero, clr_zero;

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    set_zero = HARDWIRE_ZERO && (set_idx == '0);
    clr_zero = HARDWIRE_ZERO && (clr_idx == '0);
    set_oh   = '0;
    clr_oh   = '0;
    if (set_valid) set_oh[set_idx] = 1'b1;
    if (clr_valid) clr_oh[clr_idx] = 1'b1;

    // A register retiring this cycle may be reissued in the same cycle.
    set_ready = !busy_q[set_idx] || (clr_valid && (clr_idx == set_idx)) || set_zero;
    set_acc   = set_valid && set_ready;

    busy_d = (busy_q & ~clr_oh) | (set_acc ? set_oh : '0);
    if (HARDWIRE_ZERO) busy_d[0] = 1'b0;

    // Set+clear of the same busy index nets to zero: set_new needs an idle bit, clr_hit excludes a re-set.
    set_new   = set_acc && !busy_q[set_idx] && !set_zero;
    clr_hit   = clr_valid && busy_q[clr_idx] && !(set_acc && (set_idx == clr_idx));
    count_d   = count_q + (N+1)'(set_new) - (N+1)'(clr_hit);
    clr_err_d = clr_valid && !busy_q[clr_idx] && !clr_zero;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q    <= '0;
      count_q   <= '0;
      clr_err_q <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      count_q   <= count_d;
      clr_err_q <= clr_err_d;
    end
  end

`ifdef SCOREBOARD_CLR_BYPASS_EN
  assign rs1_busy = busy_q[rs1_idx] && !(clr_valid && (clr_idx == rs1_idx));
  assign rs2_busy = busy_q[rs2_idx] && !(clr_valid && (clr_idx == rs2_idx));
`else
  assign rs1_busy = busy_q[rs1_idx];
  assign rs2_busy = busy_q[rs2_idx];
`endif

  assign busy_vec   = busy_q;
  assign busy_count = count_q;
  assign any_busy   = (count_q != '0);
  assign clr_err    = clr_err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench for reg_scoreboard: stimulus queues cycle-stamped expectations,
// a negedge monitor pops and compares them when their cycle arrives.
module tb_reg_scoreboard;

  localparam int N = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            set_valid = 1'b0;
  logic [N-1:0]    set_idx = '0;
  logic            set_ready;
  logic            clr_valid = 1'b0;
  logic [N-1:0]    clr_idx = '0;
  logic [N-1:0]    rs1_idx = '0;
  logic [N-1:0]    rs2_idx = '0;
  logic            rs1_busy, rs2_busy;
  logic [2**N-1:0] busy_vec;
  logic [N:0]      busy_count;
  logic            any_busy, clr_err;

  reg_scoreboard #(.N(N), .HARDWIRE_ZERO(1'b1)) dut (
    .clk(clk), .rst(rst),
    .set_valid(set_valid), .set_idx(set_idx), .set_ready(set_ready),
    .clr_valid(clr_valid), .clr_idx(clr_idx),
    .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .busy_vec(busy_vec), .busy_count(busy_count),
    .any_busy(any_busy), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  typedef enum {S_VEC, S_CNT, S_ANY, S_ERR, S_RDY, S_RS1, S_RS2} sel_e;
  typedef struct {
    int          cyc;
    sel_e        sel;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(input sel_e s);
    case (s)
      S_VEC:   return busy_vec;
      S_CNT:   return 32'(busy_count);
      S_ANY:   return 32'(any_busy);
      S_ERR:   return 32'(clr_err);
      S_RDY:   return 32'(set_ready);
      S_RS1:   return 32'(rs1_busy);
      default: return 32'(rs2_busy);
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Expectation for the cycle dc cycles after the current one (0 = combinational, 1 = registered).
  task automatic push_exp(input int dc, input sel_e s, input logic [31:0] v, input string nm);
    exp_t e;
    e.cyc = cyc + dc; e.sel = s; e.val = v; e.name = nm;
    sb.push_back(e);
  endtask

  // Monitor: compare every expectation stamped for the current cycle, away from the active edge.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        check(sb[i].name, actual(sb[i].sel), sb[i].val);
        sb.delete(i);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    tick();
    push_exp(0, S_VEC, 0, "reset_busy_vec");
    push_exp(0, S_CNT, 0, "reset_busy_count");
    push_exp(0, S_ANY, 0, "reset_any_busy");
    push_exp(0, S_ERR, 0, "reset_clr_err");
    rst = 1'b0;

    // Issue r5; query does not see the same-cycle set.
    tick();
    set_valid = 1'b1; set_idx = 5; rs1_idx = 5;
    push_exp(0, S_RDY, 1, "set5_ready");
    push_exp(0, S_RS1, 0, "set5_rs1_same_cycle");
    push_exp(1, S_VEC, 32'h0000_0020, "set5_busy_vec");
    push_exp(1, S_CNT, 1, "set5_count");
    push_exp(1, S_ANY, 1, "set5_any_busy");
    push_exp(1, S_RS1, 1, "set5_rs1_busy");

    // Reissue r5 while busy: WAW stall.
    tick();
    push_exp(0, S_RDY, 0, "waw_ready_low");
    push_exp(1, S_CNT, 1, "waw_count_hold");
    push_exp(1, S_VEC, 32'h0000_0020, "waw_vec_hold");

    // Reissue r5 while it retires: accepted, net count unchanged.
    tick();
    clr_valid = 1'b1; clr_idx = 5;
    push_exp(0, S_RDY, 1, "reissue_ready");
    push_exp(1, S_VEC, 32'h0000_0020, "reissue_vec");
    push_exp(1, S_CNT, 1, "reissue_count");
    push_exp(1, S_ERR, 0, "reissue_no_err");

    tick();
    set_valid = 1'b0;
    push_exp(1, S_VEC, 0, "clr5_vec");
    push_exp(1, S_CNT, 0, "clr5_count");

    tick();
    clr_valid = 1'b0; set_valid = 1'b1; set_idx = 7;
    push_exp(1, S_VEC, 32'h0000_0080, "set7_vec");

    // Set r3 and clear r7 together.
    tick();
    set_idx = 3; clr_valid = 1'b1; clr_idx = 7;
    push_exp(1, S_VEC, 32'h0000_0008, "set3_clr7_vec");
    push_exp(1, S_CNT, 1, "set3_clr7_count");

    tick();
    set_valid = 1'b0; clr_idx = 3;
    push_exp(1, S_CNT, 0, "clr3_count");

    // Spurious clear of idle r9.
    tick();
    clr_idx = 9;
    push_exp(1, S_ERR, 1, "spurious_clr_err");
    push_exp(1, S_VEC, 0, "spurious_vec");

    tick();
    clr_valid = 1'b0;
    push_exp(1, S_ERR, 0, "clr_err_one_cycle");

    // Clearing r0 is silent.
    tick();
    clr_valid = 1'b1; clr_idx = 0;
    push_exp(1, S_ERR, 0, "clr0_silent");

    // Setting r0 is accepted but never recorded.
    tick();
    clr_valid = 1'b0; set_valid = 1'b1; set_idx = 0;
    push_exp(0, S_RDY, 1, "set0_ready");
    push_exp(1, S_VEC, 0, "set0_vec");
    push_exp(1, S_CNT, 0, "set0_count");

    for (int i = 1; i < 32; i++) begin
      tick();
      set_idx = N'(i);
      push_exp(0, S_RDY, 1, $sformatf("fill_ready_%0d", i));
    end

    // Full scoreboard: per-index stall only.
    tick();
    set_idx = 12;
    push_exp(0, S_VEC, 32'hFFFF_FFFE, "full_vec");
    push_exp(0, S_CNT, 31, "full_count");
    push_exp(0, S_RDY, 0, "full_ready_12");
    push_exp(1, S_CNT, 31, "full_count_hold");

    tick();
    set_idx = 0;
    push_exp(0, S_RDY, 1, "full_ready_0");

    // Reset overrides a same-cycle set.
    tick();
    rst = 1'b1; set_idx = 12; clr_valid = 1'b1; clr_idx = 9;
    push_exp(1, S_VEC, 0, "rst_vec");
    push_exp(1, S_CNT, 0, "rst_count");
    push_exp(1, S_ANY, 0, "rst_any");
    push_exp(1, S_ERR, 0, "rst_err");

    tick();
    rst = 1'b0; clr_valid = 1'b0; set_idx = 4;

    // r4 retires while queried; r9 issues while queried on rs2.
    tick();
    set_idx = 9; rs1_idx = 4; rs2_idx = 9; clr_valid = 1'b1; clr_idx = 4;
`ifdef SCOREBOARD_CLR_BYPASS_EN
    push_exp(0, S_RS1, 0, "bypass_rs1_same_cycle");
`else
    push_exp(0, S_RS1, 1, "nobypass_rs1_same_cycle");
`endif
    push_exp(0, S_RS2, 0, "rs2_same_cycle_set");
    push_exp(1, S_RS1, 0, "rs1_after_clear");
    push_exp(1, S_RS2, 1, "rs2_after_set");
    push_exp(1, S_VEC, 32'h0000_0200, "final_vec");

    tick();
    set_valid = 1'b0; clr_valid = 1'b0;
    repeat (3) tick();

    check("scoreboard_drained", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
